// File: rtl/sq_pkg.sv
// sq_pkg: shared definitions for the sequential shift-add squarer.
//   - sq_state_t : 4-bit FSM state codes exported on SQstate
//                  (IDLE=0, LOAD=1, ITER=2, DONE=3; codes 4..15 unused)
//   - SQ_N_WIDTH : default root width
//   - SQ_CNT_W   : default iteration counter width
//   - clog2()    : ceiling log2, used to check that CNT_W can count N_WIDTH steps
package sq_pkg;

  localparam int SQ_N_WIDTH = 10;
  localparam int SQ_CNT_W   = 4;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    LOAD = 4'd1,
    ITER = 4'd2,
    DONE = 4'd3
  } sq_state_t;

  function automatic int clog2(input int value);
    int result;
    int rest;
    result = 0;
    rest   = value - 1;
    while (rest > 0) begin
      result = result + 1;
      rest   = rest >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sq_du.sv
// sq_du: datapath of the shift-add squarer.
//   Holds accumulator A (2N bits), multiplicand M (2N bits), multiplier Q (N bits),
//   the iteration counter and the output register.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   ldq                 capture data_in into Q and M (and ref_in when enabled)
//   lda                 clear A and the counter
//   shft                one iteration step: A update, M<<1, Q>>1, counter++
//   add                 add M into A during this step (controller passes Q[0] back)
//   ldo                 load data_out with the final accumulator value
//   data_in             root operand
//   q0                  status: current LSB of Q
//   cnt_last            status: the current step is the last one
//   data_out            registered square
// Optional (macro SQ_ROOTCHK_EN):
//   ref_in              candidate radicand, latched with data_in
//   root_ok             registered check: A <= ref_in < A + 2*root + 1
module sq_du
  import sq_pkg::*;
#(
  parameter int N_WIDTH = SQ_N_WIDTH,
  parameter int CNT_W   = SQ_CNT_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ldq,
  input  logic                   lda,
  input  logic                   shft,
  input  logic                   add,
  input  logic                   ldo,
  input  logic [N_WIDTH-1:0]     data_in,
`ifdef SQ_ROOTCHK_EN
  input  logic [2*N_WIDTH-1:0]   ref_in,
  output logic                   root_ok,
`endif
  output logic                   q0,
  output logic                   cnt_last,
  output logic [2*N_WIDTH-1:0]   data_out
);

  logic [2*N_WIDTH-1:0] acc;
  logic [2*N_WIDTH-1:0] mcand;
  logic [N_WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]     cnt;
  logic [2*N_WIDTH-1:0] a_sum;

  // The largest partial sum is (2^N-1)^2 < 2^(2N), so the 2N-bit add never overflows.
  assign a_sum    = acc + (add ? mcand : '0);
  assign q0       = mplier[0];
  assign cnt_last = (cnt == CNT_W'(N_WIDTH - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      data_out <= '0;
    end else begin
      if (ldq) begin
        mplier <= data_in;
        mcand  <= {{N_WIDTH{1'b0}}, data_in};
      end
      if (lda) begin
        acc <= '0;
        cnt <= '0;
      end
      if (shft) begin
        acc    <= a_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
      end
      // Output is taken from the adder on the final step so that the result
      // is already valid in the cycle where sq_done is high.
      if (ldo) begin
        data_out <= a_sum;
      end
    end
  end

`ifdef SQ_ROOTCHK_EN
  localparam int EW = 2 * N_WIDTH + 1;

  logic [N_WIDTH-1:0]   root_q;
  logic [2*N_WIDTH-1:0] ref_q;
  logic [EW-1:0]        sq_ext;
  logic [EW-1:0]        ref_ext;
  logic [EW-1:0]        upper_ext;

  // One extra bit keeps root = 2^N-1 from wrapping: (root+1)^2 = 2^(2N).
  assign sq_ext    = EW'(a_sum);
  assign ref_ext   = EW'(ref_q);
  assign upper_ext = sq_ext + EW'({root_q, 1'b0}) + EW'(1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      root_q  <= '0;
      ref_q   <= '0;
      root_ok <= 1'b0;
    end else begin
      if (ldq) begin
        root_q <= data_in;
        ref_q  <= ref_in;
      end
      if (ldo) begin
        root_ok <= (sq_ext <= ref_ext) && (ref_ext < upper_ext);
      end
    end
  end
`endif

endmodule

// File: rtl/sq_cudu.sv
// sq_cudu: sequential shift-add squarer, data_out = data_in * data_in.
//   Fixed latency: a start accepted at edge k gives sq_done high in the cycle
//   after edge k+N_WIDTH+1; one result per N_WIDTH+3 cycles back to back.
// Ports:
//   clock     rising-edge clock
//   reset     synchronous, active-low reset
//   sq_start  start request, sampled only in IDLE
//   data_in   N_WIDTH-bit root, captured on the accepted start
//   sq_done   one-cycle completion pulse
//   data_out  2*N_WIDTH-bit square, held until the next result or reset
//   SQstate   current FSM state code (IDLE=0, LOAD=1, ITER=2, DONE=3)
// Optional feature, macro SQ_ROOTCHK_EN:
//   ref_in    2*N_WIDTH-bit candidate radicand, latched with data_in
//   root_ok   1 when data_in is the integer square root of ref_in
module sq_cudu
  import sq_pkg::*;
#(
  parameter int N_WIDTH = SQ_N_WIDTH,
  parameter int CNT_W   = SQ_CNT_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sq_start,
  input  logic [N_WIDTH-1:0]     data_in,
`ifdef SQ_ROOTCHK_EN
  input  logic [2*N_WIDTH-1:0]   ref_in,
  output logic                   root_ok,
`endif
  output logic                   sq_done,
  output logic [2*N_WIDTH-1:0]   data_out,
  output logic [3:0]             SQstate
);

  if (CNT_W < clog2(N_WIDTH + 1)) begin : g_cnt_w_check
    $error("sq_cudu: CNT_W too small to count N_WIDTH iterations");
  end

  sq_state_t state;

  logic ldq;
  logic lda;
  logic shft;
  logic add;
  logic ldo;
  logic q0;
  logic cnt_last;

  assign ldq  = (state == IDLE) && sq_start;
  assign lda  = (state == LOAD);
  assign shft = (state == ITER);
  assign add  = shft && q0;
  assign ldo  = shft && cnt_last;

  assign SQstate = state;

  // sq_done is raised on the edge that enters DONE, so it is high exactly
  // while the FSM sits in DONE. Unused codes fall back to IDLE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      sq_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sq_done <= 1'b0;
          if (sq_start) state <= LOAD;
        end
        LOAD: begin
          sq_done <= 1'b0;
          state   <= ITER;
        end
        ITER: begin
          if (cnt_last) begin
            state   <= DONE;
            sq_done <= 1'b1;
          end else begin
            sq_done <= 1'b0;
          end
        end
        DONE: begin
          sq_done <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          sq_done <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  sq_du #(
    .N_WIDTH (N_WIDTH),
    .CNT_W   (CNT_W)
  ) u_du (
    .clock    (clock),
    .reset    (reset),
    .ldq      (ldq),
    .lda      (lda),
    .shft     (shft),
    .add      (add),
    .ldo      (ldo),
    .data_in  (data_in),
`ifdef SQ_ROOTCHK_EN
    .ref_in   (ref_in),
    .root_ok  (root_ok),
`endif
    .q0       (q0),
    .cnt_last (cnt_last),
    .data_out (data_out)
  );

endmodule

// File: tb/tb_sq_cudu.sv
// tb_sq_cudu: scoreboard bench for sq_cudu (N_WIDTH=10).
// Stimulus pushes the expected square, the accept edge and (with SQ_ROOTCHK_EN)
// the expected root_ok; the monitor pops one entry per sq_done pulse.
module tb_sq_cudu;

  localparam int N   = 10;
  localparam int W2  = 2 * N;
  localparam int LAT = N + 1;

  logic          clock;
  logic          reset;
  logic          sq_start;
  logic [N-1:0]  data_in;
  logic          sq_done;
  logic [W2-1:0] data_out;
  logic [3:0]    SQstate;
`ifdef SQ_ROOTCHK_EN
  logic [W2-1:0] ref_in;
  logic          root_ok;
`endif

  typedef struct {
    logic [W2-1:0] sq;
    int            acc_cyc;
    logic          ok;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   tests  = 0;
  int   failed = 0;

  sq_cudu #(.N_WIDTH(N), .CNT_W(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .sq_start (sq_start),
    .data_in  (data_in),
`ifdef SQ_ROOTCHK_EN
    .ref_in   (ref_in),
    .root_ok  (root_ok),
`endif
    .sq_done  (sq_done),
    .data_out (data_out),
    .SQstate  (SQstate)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    tests = tests + 1;
    if (act !== req) begin
      failed = failed + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clock) begin
    if (sq_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests  = tests + 1;
        failed = failed + 1;
        $display("[TB] FAIL spurious_done: got done with no request, expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("data_out", 32'(data_out), 32'(e.sq));
        check_output("latency", 32'(cyc - e.acc_cyc), 32'(LAT));
        check_output("state_at_done", 32'(SQstate), 32'd3);
`ifdef SQ_ROOTCHK_EN
        check_output("root_ok", 32'(root_ok), 32'(e.ok));
`endif
      end
    end
  end

  task automatic push_exp(input logic [W2-1:0] sq, input logic ok);
    exp_t e;
    e.sq      = sq;
    e.acc_cyc = cyc;
    e.ok      = ok;
    exp_q.push_back(e);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the
  // DUT is back in IDLE (edge k+12), ready for the next accept at k+13.
  task automatic apply_stimulus(input logic [N-1:0] root, input logic [W2-1:0] refv,
                                input logic [W2-1:0] sq, input logic ok);
    sq_start = 1'b1;
    data_in  = root;
`ifdef SQ_ROOTCHK_EN
    ref_in   = refv;
`else
    if (refv != refv) $display("[TB] unused ref");
`endif
    @(posedge clock);
    @(negedge clock);
    push_exp(sq, ok);
    sq_start = 1'b0;
    data_in  = N'($urandom);
`ifdef SQ_ROOTCHK_EN
    ref_in   = W2'($urandom);
`endif
    repeat (12) @(negedge clock);
  endtask

  initial begin
    reset    = 1'b0;
    sq_start = 1'b0;
    data_in  = '0;
`ifdef SQ_ROOTCHK_EN
    ref_in   = '0;
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    check_output("reset_data_out", 32'(data_out), 32'd0);
    check_output("reset_sq_done", 32'(sq_done), 32'd0);
    check_output("reset_state", 32'(SQstate), 32'd0);

    // Directed squares, including the extremes and a single-bit root.
    apply_stimulus(10'd5,    20'd0,      20'd25,     1'b0);
    apply_stimulus(10'd0,    20'd0,      20'd0,      1'b1);
    apply_stimulus(10'd1023, 20'hFFFFF,  20'hFF801,  1'b1);
    apply_stimulus(10'd512,  20'd0,      20'h40000,  1'b0);

    // Start held high: 3 accepted first, 7 accepted on the next IDLE cycle.
    sq_start = 1'b1;
    data_in  = 10'd3;
`ifdef SQ_ROOTCHK_EN
    ref_in   = 20'd9;
`endif
    @(posedge clock);
    @(negedge clock);
    push_exp(20'd9, 1'b1);
    data_in = 10'd7;
`ifdef SQ_ROOTCHK_EN
    ref_in  = 20'd50;
`endif
    repeat (12) @(negedge clock);
    @(negedge clock);
    push_exp(20'd49, 1'b1);
    check_output("held_state_load", 32'(SQstate), 32'd1);
    sq_start = 1'b0;
    repeat (12) @(negedge clock);

    // Start pulses while iterating must not produce extra results.
    sq_start = 1'b1;
    data_in  = 10'd6;
`ifdef SQ_ROOTCHK_EN
    ref_in   = 20'd48;
`endif
    @(posedge clock);
    @(negedge clock);
    push_exp(20'd36, 1'b1);
    sq_start = 1'b0;
    data_in  = 10'd9;
    repeat (3) @(negedge clock);
    sq_start = 1'b1;
    @(negedge clock);
    sq_start = 1'b0;
    @(negedge clock);
    sq_start = 1'b1;
    @(negedge clock);
    sq_start = 1'b0;
    repeat (20) @(negedge clock);

    // Reset in the middle of an operation discards it.
    sq_start = 1'b1;
    data_in  = 10'd700;
    @(posedge clock);
    @(negedge clock);
    sq_start = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check_output("midreset_data_out", 32'(data_out), 32'd0);
    check_output("midreset_sq_done", 32'(sq_done), 32'd0);
    check_output("midreset_state", 32'(SQstate), 32'd0);
    repeat (15) @(negedge clock);
    apply_stimulus(10'd2, 20'd4, 20'd4, 1'b1);

`ifdef SQ_ROOTCHK_EN
    apply_stimulus(10'd31,   20'd1000,  20'd961,   1'b1);
    apply_stimulus(10'd31,   20'd1024,  20'd961,   1'b0);
    apply_stimulus(10'd31,   20'd960,   20'd961,   1'b0);
    apply_stimulus(10'd1023, 20'hFFFFF, 20'hFF801, 1'b1);
`endif

    // Full sweep; ref_in = root*root + root always lies in the accepted window.
    for (int r = 0; r < 1024; r++) begin
      apply_stimulus(N'(r), W2'(r * r + r), W2'(r * r), 1'b1);
    end

    repeat (4) @(negedge clock);
    check_output("pending_results", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sq_cudu.md
Name: sq_cudu

Overview:
- Sequential shift-add squarer: takes an N-bit root, returns its 2N-bit square.
- Inverse of the square-root unit. Used to regenerate radicands for loop-back checking of sqrt results, and anywhere a cheap multiplier-free square is needed.
- Uses the same start/done handshake and state-export convention as the sqrt core, so both can share one controlling FSM.

Parameters:
- N_WIDTH, 10, root (input) width; output width is 2*N_WIDTH.
- CNT_W, 4, iteration counter width; must satisfy 2**CNT_W > N_WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- sq_start  in  1  start request, sampled only in IDLE.
- data_in  in  N_WIDTH  root to square, captured on the accepted start.
- sq_done  out  1  one-cycle pulse; data_out is valid from this cycle.
- data_out  out  2*N_WIDTH  square result.
- SQstate  out  4  current FSM state code, for debug/monitor.

Behaviour:
- Reset (reset==0 at a clock edge), including mid-operation:
  - state returns to IDLE;
  - sq_done=0, data_out=0, SQstate=4'd0;
  - accumulator, multiplicand, multiplier and counter cleared;
  - any in-flight operation is discarded with no done pulse.
- State codes on SQstate:
  - IDLE=0, LOAD=1, ITER=2, DONE=3;
  - upper codes unused; an illegal state recovers to IDLE next cycle.
- IDLE:
  - sq_start=1 -> LOAD; data_in latched into multiplier Q (N bits) and multiplicand M = zero-extended to 2N bits.
  - sq_start=0 -> stay in IDLE.
- LOAD: accumulator A=0, counter=0 -> ITER.
- ITER, one step per cycle:
  - if Q[0], A <= A + M (2N-bit add; no overflow possible);
  - M <= M<<1; Q <= Q>>1; counter++;
  - after the N_WIDTH-th step -> DONE.
- DONE:
  - data_out <= A; sq_done=1 for exactly this one cycle -> IDLE.
  - data_out holds its value until the next DONE or reset.
- Latency:
  - start accepted at edge k -> sq_done high in the cycle after edge k+N_WIDTH+1 (12 cycles for N_WIDTH=10);
  - fixed and data-independent; no early exit on Q==0.
- Handshake:
  - sq_start is ignored outside IDLE; a held-high start neither aborts nor queues.
  - Start held high through DONE begins a new operation on the first IDLE cycle.
  - Back-to-back throughput is one result per N_WIDTH+3 cycles.
- data_in may change freely after the accepted start.

Optional Feature:
- Macro: SQ_ROOTCHK_EN.
- With macro defined:
  - extra ports ref_in (in, 2*N_WIDTH) and root_ok (out, 1).
  - ref_in is latched alongside data_in.
  - In DONE, root_ok <= (A <= ref_in) && (ref_in < A + 2*root + 1), computed at 2N+1 bits so root=2^N-1 cannot overflow.
  - root_ok updates only in DONE; reset value 0.
  - This lets a bench or a system FSM verify a sqrt result in hardware.
- Without macro: ports absent; no comparator logic.

Decomposition:
- Package sq_pkg holds:
  - state encoding constants IDLE/LOAD/ITER/DONE (4-bit);
  - default N_WIDTH;
  - function clog2 for CNT_W checks.
- A controller/datapath split matches the sqrt core:
  - sub-module sq_du (A, M, Q registers, adder, counter, optional comparator);
  - FSM kept in the top sq_cudu.
  - Control strobes: ldq, lda, shft, ldo; status: q0, cnt_last.

Test Plan:
- Reset low 2 cycles, release -> data_out=0, sq_done=0, SQstate=0; data_in=5 with start pulsed -> data_out=25, sq_done high exactly 12 cycles after start edge, for one cycle.
- data_in=0 -> data_out=0 after 12 cycles; data_in=1023 -> data_out=20'hFF801 (1046529); data_in=512 -> 20'h40000.
- Start held high continuously with data_in=3 then 7 -> results 9 then 49, done pulses 13 cycles apart; start pulses during ITER produce no extra result.
- Start with data_in=700, reset low on cycle 6 -> no done pulse, data_out=0, SQstate=0; a following start with data_in=2 -> 4.
- SQ_ROOTCHK_EN: data_in=31, ref_in=1000 -> root_ok=1; ref_in=1024 -> 0; ref_in=960 -> 0; data_in=1023, ref_in=20'hFFFFF -> 1.
- Exhaustive sweep data_in=0..1023 against a reference model; all squares match, with constant 12-cycle latency.
